exe_stage: RTL

EXE_STAGE -- requirements
Module: exe_stage

---
 rtl/riscv_pkg.sv | 60 ++++++
 rtl/div_iter.sv | 54 +++++
 rtl/exe_stage.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath widths, instruction IDs from decode
// and the EXE-stage divider FSM encoding.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int GPR_ADDR_W = 5;
  localparam int INST_ID_W  = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } exe_state_e;

  // ID 0 and anything above ID_REMU is not a valid instruction
  localparam logic [INST_ID_W-1:0] ID_ADD    = 6'd1;
  localparam logic [INST_ID_W-1:0] ID_SUB    = 6'd2;
  localparam logic [INST_ID_W-1:0] ID_AND    = 6'd3;
  localparam logic [INST_ID_W-1:0] ID_OR     = 6'd4;
  localparam logic [INST_ID_W-1:0] ID_XOR    = 6'd5;
  localparam logic [INST_ID_W-1:0] ID_SLL    = 6'd6;
  localparam logic [INST_ID_W-1:0] ID_SRL    = 6'd7;
  localparam logic [INST_ID_W-1:0] ID_SRA    = 6'd8;
  localparam logic [INST_ID_W-1:0] ID_SLT    = 6'd9;
  localparam logic [INST_ID_W-1:0] ID_SLTU   = 6'd10;
  localparam logic [INST_ID_W-1:0] ID_ADDI   = 6'd11;
  localparam logic [INST_ID_W-1:0] ID_ANDI   = 6'd12;
  localparam logic [INST_ID_W-1:0] ID_ORI    = 6'd13;
  localparam logic [INST_ID_W-1:0] ID_XORI   = 6'd14;
  localparam logic [INST_ID_W-1:0] ID_SLLI   = 6'd15;
  localparam logic [INST_ID_W-1:0] ID_SRLI   = 6'd16;
  localparam logic [INST_ID_W-1:0] ID_SRAI   = 6'd17;
  localparam logic [INST_ID_W-1:0] ID_SLTI   = 6'd18;
  localparam logic [INST_ID_W-1:0] ID_SLTIU  = 6'd19;
  localparam logic [INST_ID_W-1:0] ID_LUI    = 6'd20;
  localparam logic [INST_ID_W-1:0] ID_AUIPC  = 6'd21;
  localparam logic [INST_ID_W-1:0] ID_JAL    = 6'd22;
  localparam logic [INST_ID_W-1:0] ID_JALR   = 6'd23;
  localparam logic [INST_ID_W-1:0] ID_BEQ    = 6'd24;
  localparam logic [INST_ID_W-1:0] ID_BNE    = 6'd25;
  localparam logic [INST_ID_W-1:0] ID_BLT    = 6'd26;
  localparam logic [INST_ID_W-1:0] ID_BGE    = 6'd27;
  localparam logic [INST_ID_W-1:0] ID_BLTU   = 6'd28;
  localparam logic [INST_ID_W-1:0] ID_BGEU   = 6'd29;
  localparam logic [INST_ID_W-1:0] ID_LOAD   = 6'd30;
  localparam logic [INST_ID_W-1:0] ID_STORE  = 6'd31;
  localparam logic [INST_ID_W-1:0] ID_MUL    = 6'd32;
  localparam logic [INST_ID_W-1:0] ID_MULH   = 6'd33;
  localparam logic [INST_ID_W-1:0] ID_MULHSU = 6'd34;
  localparam logic [INST_ID_W-1:0] ID_MULHU  = 6'd35;
  localparam logic [INST_ID_W-1:0] ID_DIV    = 6'd36;
  localparam logic [INST_ID_W-1:0] ID_DIVU   = 6'd37;
  localparam logic [INST_ID_W-1:0] ID_REM    = 6'd38;
  localparam logic [INST_ID_W-1:0] ID_REMU   = 6'd39;

  function automatic logic is_div_id(input logic [INST_ID_W-1:0] id);
    return id inside {ID_DIV, ID_DIVU, ID_REM, ID_REMU};
  endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// done marks the cycle whose edge retires the final iteration.
module div_iter #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  dsr;
  logic [XLEN:0]    partial;
  logic             fits;

  assign partial = {remainder, quotient[XLEN-1]};
  assign fits    = partial >= {1'b0, dsr};
  assign done    = busy && (cnt == CNT_W'(DIV_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt       <= '0;
      busy      <= 1'b0;
      dsr       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (abort) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      cnt       <= '0;
      busy      <= 1'b1;
      dsr       <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (busy) begin
      remainder <= fits ? XLEN'(partial - {1'b0, dsr}) : partial[XLEN-1:0];
      quotient  <= {quotient[XLEN-2:0], fits};
      cnt       <= done ? '0 : cnt + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU/shift/branch/multiply with a registered
// EXE/MEM bundle, plus a stalling IDLE/BUSY/DONE sequencer for the divider.
module exe_stage #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int DIV_CYCLES = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [XLEN-1:0]                  pc_i,
  input  logic [XLEN-1:0]                  rs1_val_i,
  input  logic [XLEN-1:0]                  rs2_val_i,
  input  logic [XLEN-1:0]                  imm_i,
  input  logic [riscv_pkg::GPR_ADDR_W-1:0] rd_addr_i,
  input  logic                             rd_we_i,
  input  logic                             mem_re_i,
  input  logic                             mem_we_i,
  input  logic [riscv_pkg::INST_ID_W-1:0]  instr_id_i,
  input  logic                             valid_i,
  input  logic                             flush_i,
  output logic                             stall_o,
  output logic                             br_taken_o,
  output logic [XLEN-1:0]                  br_target_o,
  output logic                             valid_o,
  output logic [XLEN-1:0]                  result_o,
  output logic [XLEN-1:0]                  store_data_o,
  output logic [riscv_pkg::GPR_ADDR_W-1:0] rd_addr_o,
  output logic                             rd_we_o,
  output logic                             mem_re_o,
  output logic                             mem_we_o
);

  import riscv_pkg::*;

  localparam int SH_W = $clog2(XLEN);

  function automatic logic [XLEN-1:0] fix_sign(input logic neg, input logic [XLEN-1:0] mag);
    return neg ? ('0 - mag) : mag;
  endfunction

  exe_state_e             state_q, state_d;
  logic                   div_op, accept_div, div_start, div_busy, div_done;
  logic [XLEN-1:0]        opb, addr_sum, alu_res, target, quotient, remainder, div_res;
  logic signed [XLEN-1:0] rs1_s, opb_s;
  logic [SH_W-1:0]        shamt;
  logic                   known, wb_ok, taken, is_jump;
  logic                   signed_div, dvd_neg, dsr_neg;
  logic                   mul_sa, mul_sb;
  logic signed [XLEN:0]   mul_a, mul_b;
  logic signed [2*XLEN-1:0] mul_p;

  // division context captured at acceptance, used in DONE
  logic                   rem_p1, neg_q_p1, neg_r_p1, zero_p1, rd_we_p1;
  logic [XLEN-1:0]        dvd_p1;
  logic [GPR_ADDR_W-1:0]  rd_addr_p1;

  assign div_op     = is_div_id(instr_id_i);
  assign accept_div = valid_i && div_op && !flush_i;
  assign addr_sum   = rs1_val_i + imm_i;
  assign opb        = (instr_id_i inside {ID_ADDI, ID_ANDI, ID_ORI, ID_XORI, ID_SLLI,
                                          ID_SRLI, ID_SRAI, ID_SLTI, ID_SLTIU}) ? imm_i : rs2_val_i;
  assign rs1_s      = rs1_val_i;
  assign opb_s      = opb;
  assign shamt      = opb[SH_W-1:0];

  assign mul_sa = instr_id_i inside {ID_MULH, ID_MULHSU};
  assign mul_sb = (instr_id_i == ID_MULH);
  assign mul_a  = {mul_sa & rs1_val_i[XLEN-1], rs1_val_i};
  assign mul_b  = {mul_sb & rs2_val_i[XLEN-1], rs2_val_i};
  assign mul_p  = mul_a * mul_b;

  always_comb begin
    alu_res = '0;
    known   = 1'b1;
    wb_ok   = 1'b1;
    taken   = 1'b0;
    is_jump = 1'b0;
    case (instr_id_i)
      ID_ADD, ID_ADDI:     alu_res = rs1_val_i + opb;
      ID_SUB:              alu_res = rs1_val_i - opb;
      ID_AND, ID_ANDI:     alu_res = rs1_val_i & opb;
      ID_OR, ID_ORI:       alu_res = rs1_val_i | opb;
      ID_XOR, ID_XORI:     alu_res = rs1_val_i ^ opb;
      ID_SLL, ID_SLLI:     alu_res = rs1_val_i << shamt;
      ID_SRL, ID_SRLI:     alu_res = rs1_val_i >> shamt;
      ID_SRA, ID_SRAI:     alu_res = rs1_s >>> shamt;
      ID_SLT, ID_SLTI:     alu_res[0] = rs1_s < opb_s;
      ID_SLTU, ID_SLTIU:   alu_res[0] = rs1_val_i < opb;
      ID_LUI:              alu_res = imm_i;
      ID_AUIPC:            alu_res = pc_i + imm_i;
      ID_JAL, ID_JALR: begin
        alu_res = pc_i + XLEN'(4);
        is_jump = 1'b1;
      end
      ID_BEQ:  begin wb_ok = 1'b0; taken = rs1_val_i == rs2_val_i; end
      ID_BNE:  begin wb_ok = 1'b0; taken = rs1_val_i != rs2_val_i; end
      ID_BLT:  begin wb_ok = 1'b0; taken = $signed(rs1_val_i) <  $signed(rs2_val_i); end
      ID_BGE:  begin wb_ok = 1'b0; taken = $signed(rs1_val_i) >= $signed(rs2_val_i); end
      ID_BLTU: begin wb_ok = 1'b0; taken = rs1_val_i <  rs2_val_i; end
      ID_BGEU: begin wb_ok = 1'b0; taken = rs1_val_i >= rs2_val_i; end
      ID_LOAD:             alu_res = addr_sum;
      ID_STORE: begin
        alu_res = addr_sum;
        wb_ok   = 1'b0;
      end
      ID_MUL:                         alu_res = mul_p[XLEN-1:0];
      ID_MULH, ID_MULHSU, ID_MULHU:   alu_res = mul_p[2*XLEN-1:XLEN];
      ID_DIV, ID_DIVU, ID_REM, ID_REMU: alu_res = '0;
      default:             known = 1'b0;
    endcase
  end

  // redirect is only meaningful for a live instruction the sequencer accepts
  assign target      = (instr_id_i == ID_JALR) ? (addr_sum & ~XLEN'(1)) : (pc_i + imm_i);
  assign br_taken_o  = rst_ni && (state_q == S_IDLE) && valid_i && !flush_i && (taken || is_jump);
  assign br_target_o = rst_ni ? target : '0;

  assign signed_div = instr_id_i inside {ID_DIV, ID_REM};
  assign dvd_neg    = signed_div && rs1_val_i[XLEN-1];
  assign dsr_neg    = signed_div && rs2_val_i[XLEN-1];

  div_iter #(
    .XLEN       (XLEN),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start     (div_start),
    .abort     (flush_i),
    .dividend  (fix_sign(dvd_neg, rs1_val_i)),
    .divisor   (fix_sign(dsr_neg, rs2_val_i)),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_div) state_d = S_BUSY;
      S_BUSY:  if (div_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_comb begin
    stall_o   = 1'b0;
    div_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_o   = rst_ni && accept_div;
        div_start = accept_div;
      end
      S_BUSY:  stall_o = rst_ni && div_busy;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_p1     <= 1'b0;
      neg_q_p1   <= 1'b0;
      neg_r_p1   <= 1'b0;
      zero_p1    <= 1'b0;
      rd_we_p1   <= 1'b0;
      dvd_p1     <= '0;
      rd_addr_p1 <= '0;
    end else if (div_start) begin
      rem_p1     <= instr_id_i inside {ID_REM, ID_REMU};
      neg_q_p1   <= dvd_neg ^ dsr_neg;
      neg_r_p1   <= dvd_neg;
      zero_p1    <= (rs2_val_i == '0);
      rd_we_p1   <= rd_we_i;
      dvd_p1     <= rs1_val_i;
      rd_addr_p1 <= rd_addr_i;
    end
  end

  always_comb begin
    if (zero_p1)     div_res = rem_p1 ? dvd_p1 : '1;
    else if (rem_p1) div_res = fix_sign(neg_r_p1, remainder);
    else             div_res = fix_sign(neg_q_p1, quotient);
  end

  // EXE/MEM boundary
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o      <= 1'b0;
      result_o     <= '0;
      store_data_o <= '0;
      rd_addr_o    <= '0;
      rd_we_o      <= 1'b0;
      mem_re_o     <= 1'b0;
      mem_we_o     <= 1'b0;
    end else if (flush_i || state_q == S_BUSY || (state_q == S_IDLE && (!valid_i || div_op))) begin
      valid_o  <= 1'b0;
      rd_we_o  <= 1'b0;
      mem_re_o <= 1'b0;
      mem_we_o <= 1'b0;
    end else if (state_q == S_DONE) begin
      valid_o   <= 1'b1;
      result_o  <= div_res;
      rd_addr_o <= rd_addr_p1;
      rd_we_o   <= rd_we_p1;
      mem_re_o  <= 1'b0;
      mem_we_o  <= 1'b0;
    end else begin
      valid_o      <= 1'b1;
      result_o     <= alu_res;
      store_data_o <= rs2_val_i;
      rd_addr_o    <= rd_addr_i;
      rd_we_o      <= known && wb_ok && rd_we_i;
      mem_re_o     <= known && mem_re_i;
      mem_we_o     <= known && mem_we_i;
    end
  end

endmodule
